bus_arbiter: RTL

- Shares the single external bus master port among N per-hart bus masters in the multi-core build.
- Each hart-side BUS adapter connects to one requester slot. The arbiter drives the memory-side bus.
- Round-robin fairness with registered grants.
- A master issuing an atomic sequence keeps a lock on the bus until its atomic flag drops.

---
 rtl/arvi_bus_pkg.sv | 21 ++
 rtl/rr_pick.sv | 34 +++
 rtl/bus_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/arvi_bus_pkg.sv
// Shared bus-side types and default widths for the hart bus masters and arbiter.
package arvi_bus_pkg;

    localparam int unsigned DEF_XLEN      = 32;
    localparam int unsigned DEF_BE_W      = DEF_XLEN / 8;
    localparam int unsigned DEF_N_MASTERS = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int unsigned grant_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned GRANT_W = grant_width(DEF_N_MASTERS);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             valid
);

    int unsigned      idx;
    logic [PTR_W-1:0] sel;

    // Scan farthest-to-nearest so the nearest requester after ptr overwrites last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int unsigned i = N; i > 0; i--) begin
            idx = 32'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = PTR_W'(idx);
            if (req[sel]) begin
                winner = sel;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory-side bus among N hart bus masters,
// with registered grants and bus locking across atomic sequences.
module bus_arbiter
    import arvi_bus_pkg::*;
#(
    parameter  int unsigned N_MASTERS = DEF_N_MASTERS,
    parameter  int unsigned XLEN      = DEF_XLEN,
    parameter  int unsigned BE_W      = XLEN / 8,
    localparam int unsigned GNT_W     = grant_width(N_MASTERS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_MASTERS-1:0]      i_m_bus_en,
    input  logic [N_MASTERS-1:0]      i_m_wr_en,
    input  logic [N_MASTERS-1:0]      i_m_atomic,
    input  logic [N_MASTERS*XLEN-1:0] i_m_addr,
    input  logic [N_MASTERS*XLEN-1:0] i_m_wr_data,
    input  logic [N_MASTERS*BE_W-1:0] i_m_byte_en,
    output logic [N_MASTERS-1:0]      o_m_ack,
    output logic [XLEN-1:0]           o_m_rd_data,
    output logic                      o_bus_en,
    output logic                      o_wr_en,
    output logic [XLEN-1:0]           o_addr,
    output logic [XLEN-1:0]           o_wr_data,
    output logic [BE_W-1:0]           o_byte_en,
    input  logic                      i_ack,
    input  logic [XLEN-1:0]           i_rd_data,
    output logic [GNT_W-1:0]          o_grant_id
);

    arb_state_e       state, state_nxt;
    logic [GNT_W-1:0] grant, grant_nxt;
    logic [GNT_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [GNT_W-1:0] winner;
    logic             win_valid;

    logic             sel_bus_en;
    logic             sel_wr_en;
    logic             sel_atomic;
    logic [XLEN-1:0]  sel_addr;
    logic [XLEN-1:0]  sel_wr_data;
    logic [BE_W-1:0]  sel_byte_en;

    rr_pick #(
        .N     (N_MASTERS),
        .PTR_W (GNT_W)
    ) u_rr_pick (
        .req    (i_m_bus_en),
        .ptr    (rr_ptr),
        .winner (winner),
        .valid  (win_valid)
    );

    // Select the current owner's request signals.
    always_comb begin
        sel_bus_en  = 1'b0;
        sel_wr_en   = 1'b0;
        sel_atomic  = 1'b0;
        sel_addr    = '0;
        sel_wr_data = '0;
        sel_byte_en = '0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            if (grant == GNT_W'(k)) begin
                sel_bus_en  = i_m_bus_en[k];
                sel_wr_en   = i_m_wr_en[k];
                sel_atomic  = i_m_atomic[k];
                sel_addr    = i_m_addr[k*XLEN +: XLEN];
                sel_wr_data = i_m_wr_data[k*XLEN +: XLEN];
                sel_byte_en = i_m_byte_en[k*BE_W +: BE_W];
            end
        end
    end

    // Next-state and bus outputs; memory side is only driven while BUSY.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        rr_ptr_nxt  = rr_ptr;
        o_bus_en    = 1'b0;
        o_wr_en     = 1'b0;
        o_addr      = '0;
        o_wr_data   = '0;
        o_byte_en   = '0;
        o_m_ack     = '0;
        o_m_rd_data = '0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    grant_nxt = winner;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                o_bus_en    = sel_bus_en;
                o_wr_en     = sel_wr_en;
                o_addr      = sel_addr;
                o_wr_data   = sel_wr_data;
                o_byte_en   = sel_byte_en;
                o_m_rd_data = i_rd_data;
                o_m_ack     = N_MASTERS'(i_ack) << grant;
                if (i_ack) begin
                    rr_ptr_nxt = grant;
                    state_nxt  = sel_atomic ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                if (sel_bus_en) begin
                    state_nxt = BUSY;
                end else if (!sel_atomic) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= GNT_W'(N_MASTERS - 1);
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    assign o_grant_id = grant;

    // The owner must hold its request until the slave acks.
    a_hold_req : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (state == BUSY && !i_ack) |-> sel_bus_en);

endmodule
